// File: rtl/fir_xifu_pkg.sv
// fir_xifu_pkg: shared queue entry type and exception codes for the XIF
// coprocessor memory responder.
package fir_xifu_pkg;

    localparam logic [5:0] EXC_LOAD_MISALIGNED  = 6'd4;
    localparam logic [5:0] EXC_LOAD_ACCESS      = 6'd5;
    localparam logic [5:0] EXC_STORE_MISALIGNED = 6'd6;
    localparam logic [5:0] EXC_STORE_ACCESS     = 6'd7;

    // Width of the due-cycle stamp; must cover more than the maximum latency (8).
    localparam int unsigned DUE_W = 4;

    typedef struct packed {
        logic [3:0]       id;
        logic             we;
        logic [31:0]      rdata;
        logic [DUE_W-1:0] due;
    } fir_xifu_memq_t;

    // Misalignment has priority over an out-of-range address.
    function automatic logic [5:0] fir_xifu_exccode(
        input logic we,
        input logic misaligned,
        input logic out_of_range
    );
        logic [5:0] code;
        code = '0;
        if (misaligned) begin
            code = we ? EXC_STORE_MISALIGNED : EXC_LOAD_MISALIGNED;
        end else if (out_of_range) begin
            code = we ? EXC_STORE_ACCESS : EXC_LOAD_ACCESS;
        end
        return code;
    endfunction

endpackage

// File: rtl/fir_xifu_mem_fifo.sv
// fir_xifu_mem_fifo: in-order outstanding-transaction queue with
// parameterised depth and entry type. Push when full and pop when empty
// are ignored.
module fir_xifu_mem_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              storage_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q,  count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = storage_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state; reset empties the queue.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful between push and pop.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            storage_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fir_xifu_mem_responder.sv
// fir_xifu_mem_responder: word-addressed memory behind the XIF coprocessor
// memory interface. Requests are checked combinationally for alignment and
// range, accepted ones access memory on the acceptance edge and return a
// result exactly LATENCY cycles later, in order.
// Optional: FIR_XIFU_MEM_STALL_EN adds an LFSR-driven random back-pressure.
module fir_xifu_mem_responder
    import fir_xifu_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_valid_i,
    output logic        mem_ready_o,
    input  logic [3:0]  mem_id_i,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_we_i,
    input  logic [2:0]  mem_size_i,
    input  logic [3:0]  mem_be_i,
    input  logic [31:0] mem_wdata_i,
    output logic        mem_resp_exc_o,
    output logic [5:0]  mem_resp_exccode_o,
    output logic        mem_result_valid_o,
    output logic [3:0]  mem_result_id_o,
    output logic [31:0] mem_result_rdata_o,
    output logic        mem_result_err_o
);

    localparam int unsigned AW       = $clog2(MEM_WORDS);
    localparam logic        USE_FIFO = (LATENCY > 1);

    logic [31:0]      mem_q [MEM_WORDS];
    logic [AW-1:0]    word_idx;
    logic [31:0]      rd_word;
    logic             misaligned, out_of_range;
    logic             accept, enq, pop;
    logic             fifo_full, fifo_empty;
    logic [DUE_W-1:0] cnt_q;
    fir_xifu_memq_t   push_entry, head;
    logic             res_valid_q;
    logic [3:0]       res_id_q;
    logic [31:0]      res_rdata_q;

    assign misaligned   = (mem_size_i != 3'd2) || (mem_addr_i[1:0] != 2'b00);
    assign out_of_range = ({2'b00, mem_addr_i[31:2]} >= MEM_WORDS);
    assign word_idx     = mem_addr_i[AW+1:2];
    assign rd_word      = mem_q[word_idx];

    // Same-cycle exception response; silent while no request is presented.
    always_comb begin
        mem_resp_exc_o     = 1'b0;
        mem_resp_exccode_o = '0;
        if (mem_valid_i) begin
            mem_resp_exc_o     = misaligned || out_of_range;
            mem_resp_exccode_o = fir_xifu_exccode(mem_we_i, misaligned, out_of_range);
        end
    end

`ifdef FIR_XIFU_MEM_STALL_EN
    logic [15:0] lfsr_q;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, free-running stall source.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    assign mem_ready_o = !fifo_full && !lfsr_q[0];
`else
    assign mem_ready_o = !fifo_full;
`endif

    assign accept = mem_valid_i && mem_ready_o;
    assign enq    = accept && !mem_resp_exc_o;

    // The queue holds a due stamp one cycle before the result is shown, so
    // an entry leaves the queue into the output register and occupancy stays
    // at LATENCY-1; with LATENCY=1 the queue is bypassed entirely.
    always_comb begin
        push_entry.id    = mem_id_i;
        push_entry.we    = mem_we_i;
        push_entry.rdata = rd_word;
        push_entry.due   = cnt_q + DUE_W'(LATENCY - 1);
    end

    assign pop = USE_FIFO && !fifo_empty && (head.due == cnt_q);

    fir_xifu_mem_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fir_xifu_memq_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (enq && USE_FIFO),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Free-running cycle stamp used to time each entry's release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Result register: one-cycle valid pulse per released entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_rdata_q <= '0;
        end else begin
            res_valid_q <= 1'b0;
            if (!USE_FIFO && enq) begin
                res_valid_q <= 1'b1;
                res_id_q    <= mem_id_i;
                res_rdata_q <= mem_we_i ? '0 : rd_word;
            end else if (pop) begin
                res_valid_q <= 1'b1;
                res_id_q    <= head.id;
                res_rdata_q <= head.we ? '0 : head.rdata;
            end
        end
    end

    // Byte-enabled store on the acceptance edge; memory is never reset.
    always_ff @(posedge clk_i) begin
        if (enq && mem_we_i) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (mem_be_i[b]) begin
                    mem_q[word_idx][8*b +: 8] <= mem_wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign mem_result_valid_o = res_valid_q;
    assign mem_result_id_o    = res_id_q;
    assign mem_result_rdata_o = res_rdata_q;
    assign mem_result_err_o   = 1'b0;

endmodule

// File: tb/tb_fir_xifu_mem_responder.sv
// tb_fir_xifu_mem_responder: three responders (LATENCY 2, 4, 1) share one
// request stream; expected results are queued at issue and a monitor checks
// every result pulse for id, data and exact arrival cycle.
module tb_fir_xifu_mem_responder;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic [3:0]  mem_id = '0;
    logic [31:0] mem_addr = '0;
    logic        mem_we = 1'b0;
    logic [2:0]  mem_size = 3'd2;
    logic [3:0]  mem_be = 4'hF;
    logic [31:0] mem_wdata = '0;

    logic        rdy  [NDUT];
    logic        exc  [NDUT];
    logic [5:0]  code [NDUT];
    logic        rv   [NDUT];
    logic [3:0]  rid  [NDUT];
    logic [31:0] rdat [NDUT];
    logic        rerr [NDUT];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [3:0]  exp_id  [512];
    logic [31:0] exp_rd  [512];
    int          exp_cyc [512];
    int          exp_n = 0;
    int          rd_idx [NDUT] = '{0, 0, 0};

    logic [31:0] model_mem [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        fir_xifu_mem_responder #(
            .MEM_WORDS  (1024),
            .LATENCY    ((g == 0) ? 2 : (g == 1) ? 4 : 1),
            .FIFO_DEPTH (4)
        ) u_dut (
            .clk_i              (clk),
            .rst_i              (rst),
            .mem_valid_i        (mem_valid),
            .mem_ready_o        (rdy[g]),
            .mem_id_i           (mem_id),
            .mem_addr_i         (mem_addr),
            .mem_we_i           (mem_we),
            .mem_size_i         (mem_size),
            .mem_be_i           (mem_be),
            .mem_wdata_i        (mem_wdata),
            .mem_resp_exc_o     (exc[g]),
            .mem_resp_exccode_o (code[g]),
            .mem_result_valid_o (rv[g]),
            .mem_result_id_o    (rid[g]),
            .mem_result_rdata_o (rdat[g]),
            .mem_result_err_o   (rerr[g])
        );
    end

    function automatic int lat_of(input int g);
        return (g == 0) ? 2 : (g == 1) ? 4 : 1;
    endfunction

`ifdef FIR_XIFU_MEM_STALL_EN
    logic [15:0] lfsr_m;
    // Taps 16,14,13,11 of the polynomial map to bits 0,2,3,5 when shifting right.
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    end
    function automatic logic ready_exp();
        return !lfsr_m[0];
    endfunction
`else
    function automatic logic ready_exp();
        return 1'b1;
    endfunction
`endif

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, g, act, expv, cyc);
        end
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            if (rv[g] === 1'b1) begin
                if (rd_idx[g] >= exp_n) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result dut%0d: got id %h expected none (cycle %0d)", g, rid[g], cyc);
                end else begin
                    chk("result_id", g, 32'(rid[g]), 32'(exp_id[rd_idx[g]]));
                    chk("result_rdata", g, rdat[g], exp_rd[rd_idx[g]]);
                    chk("result_err", g, 32'(rerr[g]), 32'd0);
                    chk("result_cycle", g, cyc, exp_cyc[rd_idx[g]] + lat_of(g));
                    rd_idx[g]++;
                end
            end else if (rd_idx[g] < exp_n && cyc > exp_cyc[rd_idx[g]] + lat_of(g)) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_result dut%0d: got nothing expected id %h by cycle %0d", g,
                         exp_id[rd_idx[g]], exp_cyc[rd_idx[g]] + lat_of(g));
                rd_idx[g]++;
            end
        end
    end

    // Issue one request starting at a falling edge; retries while the
    // predicted ready is low, and returns at the falling edge after acceptance.
    task automatic req(input logic [3:0] id, input logic we, input logic [31:0] addr,
                       input logic [2:0] size, input logic [3:0] be, input logic [31:0] wdata,
                       input logic [5:0] xcode, input logic [31:0] xrdata);
        int  waits;
        bit  done;
        waits = 0;
        done  = 1'b0;
        mem_valid = 1'b1;
        mem_id    = id;
        mem_we    = we;
        mem_addr  = addr;
        mem_size  = size;
        mem_be    = be;
        mem_wdata = wdata;
        while (!done) begin
            #1;
            for (int g = 0; g < NDUT; g++) begin
                chk("exc", g, 32'(exc[g]), 32'(xcode != 6'd0));
                chk("exccode", g, 32'(code[g]), 32'(xcode));
                chk("ready", g, 32'(rdy[g]), 32'(ready_exp()));
            end
            if (ready_exp()) begin
                if (xcode == 6'd0) begin
                    exp_id[exp_n]  = id;
                    exp_rd[exp_n]  = xrdata;
                    exp_cyc[exp_n] = cyc;
                    exp_n++;
                end
                done = 1'b1;
            end else if (waits == 64) begin
                n_checks++;
                n_fail++;
                $display("FAIL ready_timeout: got ready low for 64 cycles expected acceptance");
                done = 1'b1;
            end else begin
                waits++;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        mem_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        for (int g = 0; g < NDUT; g++) begin
            chk("rst_valid", g, 32'(rv[g]), 32'd0);
            chk("rst_id", g, 32'(rid[g]), 32'd0);
            chk("rst_rdata", g, rdat[g], 32'd0);
            chk("rst_err", g, 32'(rerr[g]), 32'd0);
            chk("rst_ready", g, 32'(rdy[g]), 32'(ready_exp()));
        end
    endtask

    initial begin
        logic [3:0]  rid_r;
        logic        rwe;
        logic [3:0]  rk;
        logic [3:0]  rbe;
        logic [31:0] rdat_r;
        logic [31:0] cur;
        int          drain;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst = 1'b0;

        // Store then load, plus the exception cases.
        req(4'd1, 1'b1, 32'h0000_0000, 3'd2, 4'hF, 32'h1122_3344, 6'd0, 32'h0);
        req(4'd3, 1'b1, 32'h0000_0010, 3'd2, 4'hF, 32'hDEAD_BEEF, 6'd0, 32'h0);
        req(4'd4, 1'b0, 32'h0000_0010, 3'd2, 4'hF, 32'h0,         6'd0, 32'hDEAD_BEEF);
        req(4'd5, 1'b0, 32'h0000_0012, 3'd2, 4'hF, 32'h0,         6'd4, 32'h0);
        req(4'd6, 1'b1, 32'h0000_4000, 3'd2, 4'hF, 32'hFFFF_FFFF, 6'd7, 32'h0);
        req(4'd7, 1'b0, 32'h0000_0000, 3'd2, 4'hF, 32'h0,         6'd0, 32'h1122_3344);
        req(4'd8, 1'b1, 32'h0000_0002, 3'd2, 4'hF, 32'h5555_5555, 6'd6, 32'h0);
        req(4'd9, 1'b0, 32'h1000_0000, 3'd2, 4'hF, 32'h0,         6'd5, 32'h0);
        req(4'd10, 1'b0, 32'h0000_0020, 3'd1, 4'hF, 32'h0,        6'd4, 32'h0);
        req(4'd11, 1'b1, 32'h0000_0010, 3'd2, 4'h3, 32'hAAAA_5555, 6'd0, 32'h0);
        req(4'd12, 1'b0, 32'h0000_0010, 3'd2, 4'hF, 32'h0,        6'd0, 32'hDEAD_5555);
        req(4'd2, 1'b1, 32'h0000_0008, 3'd2, 4'hF, 32'h0BAD_F00D, 6'd0, 32'h0);
        req(4'd13, 1'b0, 32'h0000_0008, 3'd2, 4'hF, 32'h0,        6'd0, 32'h0BAD_F00D);
        idle(6);

        // Six back-to-back loads.
        req(4'd0, 1'b0, 32'h0000_0000, 3'd2, 4'hF, 32'h0, 6'd0, 32'h1122_3344);
        req(4'd1, 1'b0, 32'h0000_0010, 3'd2, 4'hF, 32'h0, 6'd0, 32'hDEAD_5555);
        req(4'd2, 1'b0, 32'h0000_0008, 3'd2, 4'hF, 32'h0, 6'd0, 32'h0BAD_F00D);
        req(4'd3, 1'b0, 32'h0000_0000, 3'd2, 4'hF, 32'h0, 6'd0, 32'h1122_3344);
        req(4'd4, 1'b0, 32'h0000_0010, 3'd2, 4'hF, 32'h0, 6'd0, 32'hDEAD_5555);
        req(4'd5, 1'b0, 32'h0000_0008, 3'd2, 4'hF, 32'h0, 6'd0, 32'h0BAD_F00D);
        idle(8);

        // Reset with transactions in flight: nothing pending may come out.
        req(4'd7, 1'b0, 32'h0000_0010, 3'd2, 4'hF, 32'h0, 6'd0, 32'hDEAD_5555);
        req(4'd8, 1'b0, 32'h0000_0010, 3'd2, 4'hF, 32'h0, 6'd0, 32'hDEAD_5555);
        req(4'd9, 1'b0, 32'h0000_0010, 3'd2, 4'hF, 32'h0, 6'd0, 32'hDEAD_5555);
        mem_valid = 1'b0;
        #2;
        rst = 1'b1;
        for (int g = 0; g < NDUT; g++) rd_idx[g] = exp_n;
        @(negedge clk);
        #1;
        chk_reset_outputs();
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        idle(10);
        req(4'd14, 1'b0, 32'h0000_0010, 3'd2, 4'hF, 32'h0, 6'd0, 32'hDEAD_5555);
        req(4'd15, 1'b0, 32'h0000_0000, 3'd2, 4'hF, 32'h0, 6'd0, 32'h1122_3344);
        idle(6);

        // Random traffic over a 16-word window at 0x100.
        for (int k = 0; k < 16; k++) begin
            model_mem[k] = 32'h1000_0000 + 32'(k) * 32'h0101_0101;
            req(4'(k), 1'b1, 32'h100 + 32'(4 * k), 3'd2, 4'hF, model_mem[k], 6'd0, 32'h0);
        end
        for (int n = 0; n < 100; n++) begin
            rid_r  = 4'($urandom_range(0, 15));
            rwe    = 1'($urandom_range(0, 1));
            rk     = 4'($urandom_range(0, 15));
            rbe    = 4'($urandom_range(0, 15));
            rdat_r = $urandom;
            cur    = model_mem[rk];
            req(rid_r, rwe, 32'h100 + 32'(4 * rk), 3'd2, rbe, rdat_r, 6'd0, rwe ? 32'h0 : cur);
            if (rwe) begin
                for (int b = 0; b < 4; b++) begin
                    if (rbe[b]) cur[8*b +: 8] = rdat_r[8*b +: 8];
                end
                model_mem[rk] = cur;
            end
        end
        mem_valid = 1'b0;

        // Drain, bounded.
        drain = 0;
        while (drain < 40 && (rd_idx[0] < exp_n || rd_idx[1] < exp_n || rd_idx[2] < exp_n)) begin
            @(negedge clk);
            drain++;
        end
        if (rd_idx[0] < exp_n || rd_idx[1] < exp_n || rd_idx[2] < exp_n) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got results outstanding expected none");
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_xifu_mem_responder.md
FIR_XIFU_MEM_RESPONDER -- requirements
Module: fir_xifu_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning internal memory size in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to result (1..8).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning outstanding-transaction capacity (FIFO_DEPTH >= LATENCY, power of two).
REQ-004 SHALL have port clk_i, input, 1, meaning the single clock; all state on rising edge.
REQ-005 SHALL have port rst_i, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port mem_valid_i, input, 1, meaning coprocessor memory request valid.
REQ-007 SHALL have port mem_ready_o, output, 1, meaning request accepted when high together with mem_valid_i.
REQ-008 SHALL have port mem_id_i, input, 4, meaning instruction id.
REQ-009 SHALL have port mem_addr_i, input, 32, meaning byte address.
REQ-010 SHALL have ports mem_we_i (input, 1, store), mem_size_i (input, 3, log2 bytes), mem_be_i (input, 4, byte enables), mem_wdata_i (input, 32, store data).
REQ-011 SHALL have ports mem_resp_exc_o (output, 1) and mem_resp_exccode_o (output, 6), meaning the same-cycle exception response.
REQ-012 SHALL have ports mem_result_valid_o (output, 1), mem_result_id_o (output, 4), mem_result_rdata_o (output, 32), mem_result_err_o (output, 1), meaning the result channel; it has no ready.

Function
REQ-013 SHALL drive mem_ready_o = !fifo_full, with no same-cycle pop credit.
REQ-014 SHALL flag misalignment combinationally: mem_size_i != 2 or mem_addr_i[1:0] != 0 gives exc=1, exccode 4 (load) or 6 (store).
REQ-015 SHALL flag mem_addr_i[31:2] >= MEM_WORDS (aligned) as exc=1, exccode 5 (load) or 7 (store).
REQ-016 SHALL drive exc=0 and exccode=0 when mem_valid_i is low.
REQ-017 SHALL neither enqueue nor access memory for an excepted accepted request, and SHALL produce no result for it.
REQ-018 SHALL write bytes selected by mem_be_i on the acceptance edge of a non-excepted store.
REQ-019 SHALL read the word on the acceptance cycle of a non-excepted load, before any same-cycle write; back-to-back store then load SHALL see the store.
REQ-020 SHALL enqueue id, we and rdata per non-excepted accepted request.
REQ-021 SHALL assert mem_result_valid_o for exactly one cycle, exactly LATENCY cycles after acceptance, in acceptance order.
REQ-022 SHALL drive mem_result_rdata_o = 0 for stores and mem_result_err_o = 0 always.
REQ-023 SHALL keep results with LATENCY=1 and one request per cycle at full throughput with no gaps.
REQ-024 SHALL hold mem_ready_o low while full and SHALL lose no entry.

Reset
REQ-025 SHALL, on rst_i assertion including mid-operation, empty the FIFO, discard in-flight results and set mem_ready_o=1, mem_result_valid_o=0, mem_result_id_o=0, mem_result_rdata_o=0, mem_result_err_o=0.
REQ-026 SHALL leave memory contents unreset.

Configuration
REQ-027 SHALL support macro FIR_XIFU_MEM_STALL_EN: when defined, a 16-bit LFSR (x^16+x^14+x^13+x^11+1, reset 16'hACE1) advances every cycle and mem_ready_o is additionally forced low when lfsr[0]=1.
REQ-028 SHALL, without FIR_XIFU_MEM_STALL_EN, include no LFSR and follow REQ-013 alone.

Structure
REQ-029 SHALL place fir_xifu_memq_t (id, we, rdata, due counter) and exccode constants (4, 5, 6, 7) in fir_xifu_pkg.
REQ-030 SHALL implement the outstanding queue as sub-module fir_xifu_mem_fifo (parameterised depth and type, push/pop/full/empty).

Verification
REQ-031 SHALL cover: store id=3 addr 0x10 data 0xDEADBEEF be=F, then load id=4 addr 0x10 -> results id3 rdata 0, then id4 rdata 0xDEADBEEF, each exactly LATENCY cycles after its acceptance.
REQ-032 SHALL cover: load addr 0x12 -> same-cycle exc=1 code 4, no result; store addr 0x4000 with MEM_WORDS=1024 -> exc=1 code 7, memory unchanged.
REQ-033 SHALL cover: 6 back-to-back loads with LATENCY=2, FIFO_DEPTH=4 -> no stalls, 6 consecutive result cycles, ids in order.
REQ-034 SHALL cover: LATENCY=4, FIFO_DEPTH=4 with continuous valid -> mem_ready_o never low, and ids returned in order.
REQ-035 SHALL cover: rst_i pulsed with 3 transactions in flight -> no result thereafter, mem_ready_o=1, and earlier memory writes still readable.
REQ-036 SHALL cover, with FIR_XIFU_MEM_STALL_EN: 100 random requests -> all results in order, with mem_ready_o low on LFSR-predicted cycles.
